me_search_scheduler: RTL and testbench

Frame-level sequencer for the integer-pel search unit. Walks macroblocks in raster order and runs an iterative 4-pixel-step search on each one: it issues req/ack transactions to the search unit, re-centres the window from the returned vector difference, and stops on convergence or after an iteration cap. It then emits one result word per macroblock over a valid/ready interface. It sits between the host/frame control and the integer search controller.

---
 rtl/me_pkg.sv | 42 ++++
 rtl/me_pos_update.sv | 39 +++
 rtl/me_search_scheduler.sv | 157 +++++++++++++++
 tb/tb_me_search_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared types and constants for the motion-estimation schedulers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package me_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_DROP   = 3'd2,
    S_EVAL   = 3'd3,
    S_EMIT   = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  // Per-axis vec_diff codes; 2'b10 is unused by the search unit and reads as zero.
  localparam logic [1:0] DIFF_ZERO = 2'b00;
  localparam logic [1:0] DIFF_POS  = 2'b01;
  localparam logic [1:0] DIFF_NEG  = 2'b11;

  // Result word field offsets (LSB of each field).
  localparam int RES_W        = 48;
  localparam int RES_ITER_LSB = 2;
  localparam int RES_SAD_LSB  = 6;
  localparam int RES_POS_LSB  = 22;
  localparam int RES_MBX_LSB  = 34;
  localparam int RES_MBY_LSB  = 41;

  localparam int          STEP_DEF       = 4;
  localparam int          MAX_ITER_DEF   = 8;
  localparam logic [5:0]  POS_MAX_DEF    = 6'd47;
  localparam logic [11:0] POS_CENTER_DEF = 12'h618;

  // Signed direction (-1/0/+1) carried by one axis of a vec_diff code.
  function automatic logic signed [7:0] diff_dir(input logic [1:0] code);
    case (code)
      DIFF_POS: diff_dir = 8'sd1;
      DIFF_NEG: diff_dir = -8'sd1;
      default:  diff_dir = 8'sd0;
    endcase
  endfunction

endpackage

// File: rtl/me_pos_update.sv
// Window-origin update: decode vec_diff, move each axis by STEP, clamp to [0, POS_MAX].
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module me_pos_update
  import me_pkg::*;
#(
  parameter int         STEP    = STEP_DEF,
  parameter logic [5:0] POS_MAX = POS_MAX_DEF
) (
  input  logic [11:0] pos,
  input  logic [3:0]  diff,
  output logic [11:0] next_pos,
  output logic        zero_diff,
  output logic        no_move
);

  localparam logic signed [7:0] STEP_S = 8'(STEP);
  localparam logic signed [7:0] MAX_S  = {2'b00, POS_MAX};

  // Signed 8-bit arithmetic keeps the -STEP underflow and the overshoot past POS_MAX visible.
  function automatic logic [5:0] axis_move(input logic [5:0] coord, input logic [1:0] code);
    logic signed [7:0] sum;
    sum = $signed({2'b00, coord}) + diff_dir(code) * STEP_S;
    if (sum < 8'sd0)
      axis_move = 6'd0;
    else if (sum > MAX_S)
      axis_move = POS_MAX;
    else
      axis_move = sum[5:0];
  endfunction

  // Both axes move together; a clamped origin equal to the current one means the search is pinned.
  always_comb begin
    next_pos  = {axis_move(pos[11:6], diff[3:2]), axis_move(pos[5:0], diff[1:0])};
    zero_diff = (diff_dir(diff[3:2]) == 8'sd0) && (diff_dir(diff[1:0]) == 8'sd0);
    no_move   = (next_pos == pos);
  end

endmodule

// File: rtl/me_search_scheduler.sv
// Frame sequencer: raster-walks macroblocks, iterates the integer search per MB, emits one result each.
// Latency: start->req 1 cycle; ack rise->next req >=3 cycles; result accept->next req 1 cycle.
// Backpressure: result held in EMIT until res_ready; no search request is issued while a result waits.
module me_search_scheduler
  import me_pkg::*;
#(
  parameter int          MAX_ITER   = MAX_ITER_DEF,
  parameter int          STEP       = STEP_DEF,
  parameter logic [5:0]  POS_MAX    = POS_MAX_DEF,
  parameter logic [11:0] POS_CENTER = POS_CENTER_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [6:0]        mb_cols,
  input  logic [6:0]        mb_rows,
  output logic              busy,
  output logic              frame_done,
  output logic              srch_req,
  input  logic              srch_ack,
  output logic [11:0]       srch_init_pos,
  input  logic [15:0]       srch_min_sad,
  input  logic [3:0]        srch_min_diff,
  output logic [6:0]        mb_x,
  output logic [6:0]        mb_y,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data
);

  state_t      state;
  logic [6:0]  cols_q, rows_q;
  logic [11:0] pos, best_pos;
  logic [15:0] best_sad, cap_sad;
  logic [3:0]  cap_diff, iter_cnt;

  logic [11:0]      nxt_pos;
  logic             zero_diff, no_move;
  logic [3:0]       iter_nx;
  logic             improved, stop, last_mb;
  logic [15:0]      sad_nx;
  logic [11:0]      bpos_nx;
  logic [RES_W-1:0] res_word;

  me_pos_update #(.STEP(STEP), .POS_MAX(POS_MAX)) u_pos_update (
    .pos       (pos),
    .diff      (cap_diff),
    .next_pos  (nxt_pos),
    .zero_diff (zero_diff),
    .no_move   (no_move)
  );

  // Handshake outputs are pure decodes of the registered state.
  assign srch_req   = (state == S_ISSUE);
  assign res_valid  = (state == S_EMIT);
  assign frame_done = (state == S_FINISH);
  assign busy       = (state == S_ISSUE) || (state == S_DROP) ||
                      (state == S_EVAL)  || (state == S_EMIT);

  // EVAL decision: strict improvement keeps the earlier origin on ties; stop checks use pre-update best.
  always_comb begin
    iter_nx  = iter_cnt + 4'd1;
    improved = (cap_sad < best_sad);
    sad_nx   = improved ? cap_sad : best_sad;
    bpos_nx  = improved ? pos : best_pos;
    stop     = zero_diff || !improved || (iter_nx == 4'(MAX_ITER)) || no_move;
    last_mb  = (mb_x == cols_q - 7'd1) && (mb_y == rows_q - 7'd1);
    res_word = '0;
    res_word[RES_MBY_LSB  +: 7]  = mb_y;
    res_word[RES_MBX_LSB  +: 7]  = mb_x;
    res_word[RES_POS_LSB  +: 12] = bpos_nx;
    res_word[RES_SAD_LSB  +: 16] = sad_nx;
    res_word[RES_ITER_LSB +: 4]  = iter_nx;
  end

  // Sequencer FSM; the result word is frozen on entry to EMIT so it stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cols_q        <= 7'd0;
      rows_q        <= 7'd0;
      mb_x          <= 7'd0;
      mb_y          <= 7'd0;
      pos           <= POS_CENTER;
      best_pos      <= POS_CENTER;
      best_sad      <= 16'hFFFF;
      iter_cnt      <= 4'd0;
      cap_sad       <= 16'd0;
      cap_diff      <= 4'd0;
      srch_init_pos <= 12'd0;
      res_data      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cols_q        <= (mb_cols == 7'd0) ? 7'd1 : mb_cols;
            rows_q        <= (mb_rows == 7'd0) ? 7'd1 : mb_rows;
            mb_x          <= 7'd0;
            mb_y          <= 7'd0;
            pos           <= POS_CENTER;
            best_pos      <= POS_CENTER;
            best_sad      <= 16'hFFFF;
            iter_cnt      <= 4'd0;
            srch_init_pos <= POS_CENTER;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (srch_ack) begin
            cap_sad  <= srch_min_sad;
            cap_diff <= srch_min_diff;
            state    <= S_DROP;
          end
        end
        S_DROP: begin
          if (!srch_ack) state <= S_EVAL;
        end
        S_EVAL: begin
          iter_cnt <= iter_nx;
          best_sad <= sad_nx;
          best_pos <= bpos_nx;
          if (stop) begin
            res_data <= res_word;
            state    <= S_EMIT;
          end else begin
            pos           <= nxt_pos;
            srch_init_pos <= nxt_pos;
            state         <= S_ISSUE;
          end
        end
        S_EMIT: begin
          if (res_ready) begin
            if (last_mb) begin
              state <= S_FINISH;
            end else begin
              if (mb_x == cols_q - 7'd1) begin
                mb_x <= 7'd0;
                mb_y <= mb_y + 7'd1;
              end else begin
                mb_x <= mb_x + 7'd1;
              end
              pos           <= POS_CENTER;
              best_pos      <= POS_CENTER;
              best_sad      <= 16'hFFFF;
              iter_cnt      <= 4'd0;
              srch_init_pos <= POS_CENTER;
              state         <= S_ISSUE;
            end
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_me_search_scheduler.sv
// Bench for me_search_scheduler: reference model fills transaction/result queues, monitors compare.
// Latency: n/a.
// Backpressure: random res_ready with an optional forced stall on one chosen result.
module tb_me_search_scheduler;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [6:0]  mb_cols, mb_rows;
  logic        busy, frame_done, srch_req, srch_ack;
  logic [11:0] srch_init_pos;
  logic [15:0] srch_min_sad;
  logic [3:0]  srch_min_diff;
  logic [6:0]  mb_x, mb_y;
  logic        res_valid, res_ready;
  logic [47:0] res_data;

  me_search_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .mb_cols(mb_cols), .mb_rows(mb_rows),
    .busy(busy), .frame_done(frame_done), .srch_req(srch_req), .srch_ack(srch_ack),
    .srch_init_pos(srch_init_pos), .srch_min_sad(srch_min_sad), .srch_min_diff(srch_min_diff),
    .mb_x(mb_x), .mb_y(mb_y), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] org;
    logic [15:0] sad;
    logic [3:0]  diff;
  } txn_t;

  txn_t        txn_q[$];
  logic [47:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;
  int fd_cnt   = 0;
  int stall_idx  = -1;
  int stall_left = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int clampi(input int v);
    return (v < 0) ? 0 : ((v > 47) ? 47 : v);
  endfunction

  function automatic int dec(input logic [1:0] c);
    return (c == 2'b01) ? 1 : ((c == 2'b11) ? -1 : 0);
  endfunction

  task automatic gen_resp(input int mode, input int k, input int prev,
                          output logic [15:0] sad, output logic [3:0] diff);
    int r;
    case (mode)
      0: begin sad = 16'd100; diff = 4'b0000; end
      1: begin
        if (k == 0)      begin sad = 16'd500; diff = 4'b0001; end
        else if (k == 1) begin sad = 16'd400; diff = 4'b0101; end
        else             begin sad = 16'd300; diff = 4'b0000; end
      end
      2: begin sad = 16'(1000 - 10 * k); diff = 4'b0001; end
      3: begin sad = 16'(1000 - 10 * k); diff = (k % 2 == 0) ? 4'b0001 : 4'b0011; end
      default: begin
        diff = 4'($urandom_range(0, 15));
        r = $urandom_range(0, 9);
        if (r == 0)      sad = 16'($urandom_range(0, 65535));
        else if (r == 1) sad = 16'(prev);
        else             sad = 16'(prev * 3 / 4);
      end
    endcase
  endtask

  task automatic model_frame(input int cols, input int rows, input int mode);
    int c, rw, px, py, bx, by, best, n, nx, ny, s;
    bit done, improved;
    logic [15:0] sad;
    logic [3:0]  diff;
    c  = (cols == 0) ? 1 : cols;
    rw = (rows == 0) ? 1 : rows;
    for (int y = 0; y < rw; y++) begin
      for (int x = 0; x < c; x++) begin
        px = 24; py = 24; bx = 24; by = 24; best = 65535; n = 0; done = 0;
        while (!done) begin
          gen_resp(mode, n, best, sad, diff);
          txn_q.push_back('{org: 12'(py * 64 + px), sad: sad, diff: diff});
          n++;
          s = int'(sad);
          improved = (s < best);
          if (improved) begin best = s; bx = px; by = py; end
          nx = clampi(px + 4 * dec(diff[1:0]));
          ny = clampi(py + 4 * dec(diff[3:2]));
          done = (dec(diff[1:0]) == 0 && dec(diff[3:2]) == 0) || !improved || (n == 8) ||
                 (nx == px && ny == py);
          if (!done) begin px = nx; py = ny; end
        end
        exp_q.push_back({7'(y), 7'(x), 6'(by), 6'(bx), 16'(best), 4'(n), 2'b00});
      end
    end
  endtask

  // ---------------- search unit responder ----------------
  initial begin : responder
    int   rs, dly;
    bit   dummy;
    txn_t cur;
    rs = 0; dly = 0; dummy = 0; cur = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        rs = 0;
        srch_ack = 1'b0;
      end else begin
        case (rs)
          0: begin
            if (txn_q.size() == 0) begin
              chk("spurious_req", {63'd0, srch_req}, 64'd0);
              if (srch_req) begin dummy = 1; cur = '0; dly = 0; rs = 1; end
            end else if (srch_req) begin
              cur = txn_q.pop_front();
              dummy = 0;
              chk("req_origin", {52'd0, srch_init_pos}, {52'd0, cur.org});
              dly = $urandom_range(0, 2);
              rs = 1;
            end
          end
          1: begin
            if (!dummy) chk("origin_stable", {52'd0, srch_init_pos}, {52'd0, cur.org});
            if (dly == 0) begin
              srch_ack = 1'b1;
              srch_min_sad = cur.sad;
              srch_min_diff = cur.diff;
              rs = 2;
            end else dly--;
          end
          2: begin
            if (!srch_req) begin dly = $urandom_range(0, 2); rs = 3; end
          end
          default: begin
            if (dly == 0) begin
              srch_ack = 1'b0;
              srch_min_sad = 16'($urandom_range(0, 65535));
              srch_min_diff = 4'($urandom_range(0, 15));
              rs = 0;
            end else dly--;
          end
        endcase
      end
    end
  end

  // ---------------- result consumer ----------------
  initial begin : ready_driver
    res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (res_valid && acc_cnt == stall_idx && stall_left > 0) begin
        res_ready = 1'b0;
        stall_left--;
      end else begin
        res_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // ---------------- result monitor ----------------
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (res_valid) begin
          if (exp_q.size() == 0) chk("unexpected_result", {63'd0, res_valid}, 64'd0);
          else chk("res_data", {16'd0, res_data}, {16'd0, exp_q[0]});
          chk("no_req_during_emit", {63'd0, srch_req}, 64'd0);
          if (res_ready) begin
            if (exp_q.size() > 0) exp_q.delete(0);
            acc_cnt++;
          end
        end
        if (frame_done) begin
          fd_cnt++;
          chk("results_left_at_done", 64'(exp_q.size()), 64'd0);
        end
      end
    end
  end

  // ---------------- sequences ----------------
  task automatic recover();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    txn_q.delete();
    exp_q.delete();
  endtask

  task automatic run_frame(input int cols, input int rows, input int mode, input int stall);
    bit seen;
    model_frame(cols, rows, mode);
    acc_cnt = 0; fd_cnt = 0; stall_idx = stall; stall_left = 5;
    @(posedge clk); #1;
    mb_cols = 7'(cols); mb_rows = 7'(rows); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_to_req", {62'd0, busy, srch_req}, 64'd3);
    mb_cols = 7'($urandom_range(0, 127));
    repeat (2) @(posedge clk);
    #1;
    if (busy) begin
      start = 1'b1;
      mb_rows = 7'($urandom_range(1, 9));
      @(posedge clk); #1;
      start = 1'b0;
    end
    seen = 0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (frame_done) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    chk("frame_done_seen", {63'd0, seen}, 64'd1);
    if (!seen) begin
      recover();
    end else begin
      @(posedge clk); #1;
      chk("done_pulse_idle", {62'd0, frame_done, busy}, 64'd0);
      chk("frame_done_count", 64'(fd_cnt), 64'd1);
      chk("txn_left", 64'(txn_q.size()), 64'd0);
      chk("res_left", 64'(exp_q.size()), 64'd0);
    end
  endtask

  task automatic mid_reset();
    int  n0;
    bit  got;
    model_frame(2, 2, 4);
    n0 = txn_q.size();
    acc_cnt = 0; stall_idx = -1;
    @(posedge clk); #1;
    mb_cols = 7'd2; mb_rows = 7'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (srch_req && (n0 - txn_q.size()) >= 2) begin got = 1; break; end
      @(posedge clk); #1;
    end
    chk("midrst_req_seen", {63'd0, got}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ctrl", {34'd0, busy, frame_done, srch_req, res_valid, srch_init_pos, mb_x, mb_y}, 64'd0);
    chk("midrst_res_data", {16'd0, res_data}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    txn_q.delete();
    exp_q.delete();
  endtask

  initial begin : main
    rst = 1'b1; start = 1'b0; mb_cols = 7'd0; mb_rows = 7'd0;
    srch_ack = 1'b0; srch_min_sad = 16'd0; srch_min_diff = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {34'd0, busy, frame_done, srch_req, res_valid, srch_init_pos, mb_x, mb_y}, 64'd0);
    chk("reset_res_data", {16'd0, res_data}, 64'd0);
    rst = 1'b0;

    run_frame(1, 1, 0, -1);   // immediate convergence
    run_frame(1, 1, 1, -1);   // scripted two moves then converge
    run_frame(1, 1, 2, -1);   // x walks to the clamp, then pinned
    run_frame(1, 1, 3, -1);   // oscillation runs into the iteration cap
    run_frame(3, 2, 4, 1);    // 3x2 frame, 2nd result stalled 5 cycles
    mid_reset();
    run_frame(0, 2, 4, -1);   // zero columns treated as one
    for (int i = 0; i < 6; i++)
      run_frame($urandom_range(1, 4), $urandom_range(1, 3), 4, $urandom_range(0, 3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
